// File: rtl/fifo_sync_gen.sv
// rtl/fifo_sync_gen.sv - parametrised single-clock FIFO with occupancy count, flush and error pulses
// Define FIFO_SYNC_GEN_FWFT_EN for first-word-fall-through read data instead of a registered read.
module fifo_sync_gen #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int PTR_WIDTH = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 wr_en_i,
   input  logic [WIDTH-1:0]     wdata_i,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic                 wr_error_o,
   input  logic                 rd_en_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 empty_o,
   output logic                 almost_empty_o,
   output logic                 rd_error_o,
   output logic [PTR_WIDTH:0]   count_o
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_WIDTH:0] AF_LVL  = AF_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AE_LVL  = AE_THRESH[PTR_WIDTH:0];

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic                 wr_err_q, wr_err_d;
   logic                 rd_err_q, rd_err_d;
   logic [PTR_WIDTH-1:0] wr_addr, rd_addr;
   logic                 wr_accept, rd_accept;

   assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
   assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

   // Flags look only at registered pointers, never at the request inputs.
   assign empty_o        = (wr_ptr_q == rd_ptr_q);
   assign full_o         = (wr_addr == rd_addr) && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
   assign count_o        = wr_ptr_q - rd_ptr_q;
   assign almost_full_o  = (count_o >= AF_LVL);
   assign almost_empty_o = (count_o <= AE_LVL);
   assign wr_error_o     = wr_err_q;
   assign rd_error_o     = rd_err_q;

   always_comb begin
      wr_accept = wr_en_i && !full_o && !flush_i;
      rd_accept = rd_en_i && !empty_o && !flush_i;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_err_d  = 1'b0;
      rd_err_d  = 1'b0;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
         wr_err_d = wr_en_i && full_o;
         rd_err_d = rd_en_i && empty_o;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_err_q <= wr_err_d;
         rd_err_q <= rd_err_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (wr_accept) mem_q[wr_addr] <= wdata_i;
   end

`ifdef FIFO_SYNC_GEN_FWFT_EN
   assign rdata_o = mem_q[rd_addr];
`else
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (rd_accept) rdata_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;
`endif

endmodule

// File: tb/tb_fifo_sync_gen.sv
// tb/tb_fifo_sync_gen.sv - self-checking bench for fifo_sync_gen against a queue model
// Honours FIFO_SYNC_GEN_FWFT_EN for the read-data expectations.
module tb_fifo_sync_gen;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rst, flush, wr_en, rd_en;
   logic [7:0] wdata, rdata;
   logic       full, af, wr_err, empty, ae, rd_err;
   logic [4:0] count;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] mq[$];
   logic [7:0] m_rdata;
   logic       m_wr_err, m_rd_err;

   typedef struct {
      logic       f, w, r;
      logic [7:0] d;
      logic [4:0] cnt;
      logic       emp, ful, werr, rerr;
      logic [7:0] rdat;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   fifo_sync_gen #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .wr_en_i(wr_en), .wdata_i(wdata), .full_o(full), .almost_full_o(af), .wr_error_o(wr_err),
      .rd_en_i(rd_en), .rdata_o(rdata), .empty_o(empty), .almost_empty_o(ae), .rd_error_o(rd_err),
      .count_o(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic f, input logic w, input logic r, input logic [7:0] d);
      int n;
      n = mq.size();
      if (f) begin
         mq.delete();
         m_wr_err = 1'b0;
         m_rd_err = 1'b0;
      end else begin
         m_wr_err = w && (n == D);
         m_rd_err = r && (n == 0);
         if (r && n != 0) m_rdata = mq.pop_front();
         if (w && n != D) mq.push_back(d);
      end
   endtask

   task automatic cycle(input logic f, input logic w, input logic r, input logic [7:0] d);
      flush = f; wr_en = w; rd_en = r; wdata = d;
      model_step(f, w, r, d);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      int n;
      n = mq.size();
      chk({tag, " count"}, 32'(count), n);
      chk({tag, " empty"}, 32'(empty), 32'(n == 0));
      chk({tag, " full"}, 32'(full), 32'(n == D));
      chk({tag, " almost_full"}, 32'(af), 32'(n >= 14));
      chk({tag, " almost_empty"}, 32'(ae), 32'(n <= 2));
      chk({tag, " wr_error"}, 32'(wr_err), 32'(m_wr_err));
      chk({tag, " rd_error"}, 32'(rd_err), 32'(m_rd_err));
`ifdef FIFO_SYNC_GEN_FWFT_EN
      if (n != 0) chk({tag, " rdata"}, 32'(rdata), 32'(mq[0]));
`else
      chk({tag, " rdata"}, 32'(rdata), 32'(m_rdata));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
      mq.delete();
      m_rdata = 8'h00; m_wr_err = 1'b0; m_rd_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //            f     w     r     d      cnt   emp   ful   werr  rerr  rdat
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h66, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};

      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
      do_reset();

      chk("reset count", 32'(count), 0);
      chk("reset empty", 32'(empty), 1);
      chk("reset full", 32'(full), 0);
      chk("reset almost_full", 32'(af), 0);
      chk("reset almost_empty", 32'(ae), 1);
      chk("reset wr_error", 32'(wr_err), 0);
      chk("reset rd_error", 32'(rd_err), 0);
`ifndef FIFO_SYNC_GEN_FWFT_EN
      chk("reset rdata", 32'(rdata), 0);
`endif

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].d);
         chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d empty", i), 32'(empty), 32'(tbl[i].emp));
         chk($sformatf("tbl%0d full", i), 32'(full), 32'(tbl[i].ful));
         chk($sformatf("tbl%0d almost_empty", i), 32'(ae), 32'(tbl[i].cnt <= 5'd2));
         chk($sformatf("tbl%0d wr_error", i), 32'(wr_err), 32'(tbl[i].werr));
         chk($sformatf("tbl%0d rd_error", i), 32'(rd_err), 32'(tbl[i].rerr));
`ifndef FIFO_SYNC_GEN_FWFT_EN
         chk($sformatf("tbl%0d rdata", i), 32'(rdata), 32'(tbl[i].rdat));
`endif
      end

      // Fill to full, then overflow.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'(i));
         check_model("fill");
         if (i == 12) chk("fill13 almost_full", 32'(af), 0);
         if (i == 13) chk("fill14 almost_full", 32'(af), 1);
      end
      chk("fill16 full", 32'(full), 1);
      chk("fill16 count", 32'(count), 16);
      cycle(1'b0, 1'b1, 1'b0, 8'hFF);
      chk("overflow wr_error", 32'(wr_err), 1);
      chk("overflow count", 32'(count), 16);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("overflow wr_error clears", 32'(wr_err), 0);

      // Drain in order, then underflow.
      for (int i = 0; i < 16; i++) begin
`ifdef FIFO_SYNC_GEN_FWFT_EN
         chk($sformatf("drain%0d rdata", i), 32'(rdata), i);
`endif
         cycle(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_SYNC_GEN_FWFT_EN
         chk($sformatf("drain%0d rdata", i), 32'(rdata), i);
`endif
         if (i == 13) chk("drain count2 almost_empty", 32'(ae), 1);
         if (i == 12) chk("drain count3 almost_empty", 32'(ae), 0);
      end
      chk("drain empty", 32'(empty), 1);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("underflow rd_error", 32'(rd_err), 1);
`ifndef FIFO_SYNC_GEN_FWFT_EN
      chk("underflow rdata holds", 32'(rdata), 32'h0F);
`endif

      // Continuous stream across two pointer wraps.
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 8'(k));
      for (int k = 3; k < 40; k++) begin
`ifdef FIFO_SYNC_GEN_FWFT_EN
         chk($sformatf("stream%0d rdata", k), 32'(rdata), k - 3);
`endif
         cycle(1'b0, 1'b1, 1'b1, 8'(k));
         chk($sformatf("stream%0d count", k), 32'(count), 3);
`ifndef FIFO_SYNC_GEN_FWFT_EN
         chk($sformatf("stream%0d rdata", k), 32'(rdata), k - 3);
`endif
      end
      for (int k = 37; k < 40; k++) begin
         cycle(1'b0, 1'b0, 1'b1, 8'h00);
         check_model("stream tail");
      end

      // Simultaneous requests at the full and empty boundaries.
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      cycle(1'b0, 1'b1, 1'b1, 8'h99);
      chk("full both wr_error", 32'(wr_err), 1);
      chk("full both count", 32'(count), 15);
`ifndef FIFO_SYNC_GEN_FWFT_EN
      chk("full both rdata", 32'(rdata), 32'h40);
`endif
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
      check_model("drained");
      cycle(1'b0, 1'b1, 1'b1, 8'h77);
      chk("empty both rd_error", 32'(rd_err), 1);
      chk("empty both count", 32'(count), 1);
      chk("empty both wr_error", 32'(wr_err), 0);

      // Flush beats a concurrent write; async reset acts without a clock edge.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
      cycle(1'b1, 1'b1, 1'b0, 8'h12);
      chk("flush count", 32'(count), 0);
      chk("flush empty", 32'(empty), 1);
      chk("flush wr_error", 32'(wr_err), 0);
      chk("flush rd_error", 32'(rd_err), 0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
      cycle(1'b0, 1'b1, 1'b1, 8'h73);
      #2;
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      #1;
      chk("async rst empty", 32'(empty), 1);
      chk("async rst count", 32'(count), 0);
      chk("async rst almost_empty", 32'(ae), 1);
      chk("async rst full", 32'(full), 0);
`ifndef FIFO_SYNC_GEN_FWFT_EN
      chk("async rst rdata", 32'(rdata), 0);
`endif
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 8'hC3);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      check_model("post reset");

`ifdef FIFO_SYNC_GEN_FWFT_EN
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 8'hA5);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft rdata without rd_en", 32'(rdata), 32'hA5);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      chk("fwft pop empty", 32'(empty), 1);
`endif

      // Randomised traffic: write-heavy half, then read-heavy half.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int wb;
         logic f, w, r;
         wb = (c < 1500) ? 70 : 30;
         f = ($urandom_range(99) < 2);
         w = ($urandom_range(99) < wb);
         r = ($urandom_range(99) < (100 - wb));
         cycle(f, w, r, 8'($urandom));
         check_model("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
